// File: rtl/cla_nibble_seq_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder/subtractor.
// Holds the controller state encoding, the slice width and the index-width helper.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIB_W = 4;

    // A single-nibble operation still needs a one-bit index register.
    function automatic int idx_w(input int nib);
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

endpackage

// File: rtl/cla_nibble_seq_slice.sv
// Combinational 4-bit carry-lookahead slice; also exposes the carry into bit 3
// so the controller can form signed overflow on the final pass.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       c3,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < 4; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        s  = p ^ c[3:0];
        c3 = c[3];
        co = c[4];
    end

endmodule

// File: rtl/cla_nibble_seq.sv
// Sequences one cla4_slice across a WIDTH-bit operand pair, LS nibble first,
// with valid/ready handshakes on the operand and result sides.
module cla_nibble_seq
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB = WIDTH / NIB_W;
    localparam int KW  = idx_w(NIB);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [3:0]       sl_s;
    logic             sl_c3;
    logic             sl_co;

    // Operands shift right each pass, so the slice always sees bits [3:0].
    cla4_slice u_slice (
        .a  (a_q[3:0]),
        .b  (b_q[3:0]),
        .ci (carry_q),
        .s  (sl_s),
        .c3 (sl_c3),
        .co (sl_co)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        k_d      = k_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = cin ^ sub;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d = a_q >> NIB_W;
                b_d = b_q >> NIB_W;
                result_d[int'(k_q)*NIB_W +: NIB_W] = sl_s;
                carry_d = sl_co;
                k_d     = k_q + 1'b1;
                if (k_q == KW'(NIB - 1)) begin
                    cout_d  = sl_co;
                    ovf_d   = sl_c3 ^ sl_co;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Operand shadow registers are pure data; their contents only matter in RUN.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE) && !rst;
    assign result    = result_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_nibble_seq.sv
// Bench for cla_nibble_seq (WIDTH=16): vector table plus hand-written sequences
// for reset, backpressure and mid-operation abort, checked through a result queue.
module tb_cla_nibble_seq;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t exp_q[$];

    cla_nibble_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, input logic c,
                                input logic [W-1:0] res, input logic co, input logic ov);
        vec_t v;
        v.a = a; v.b = b; v.sub = s; v.cin = c; v.res = res; v.co = co; v.ov = ov;
        return v;
    endfunction

    // Full-width reference: plain wide addition, overflow from operand/result signs.
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic c);
        logic [W-1:0] bb;
        logic [W:0]   f;
        vec_t         v;
        bb = s ? ~b : b;
        f  = {1'b0, a} + {1'b0, bb} + (W+1)'(c ^ s);
        v  = mk(a, b, s, c, f[W-1:0], f[W], (a[W-1] == bb[W-1]) && (f[W-1] != a[W-1]));
        return v;
    endfunction

    // Scoreboard: every completed output handshake consumes one expected record.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got result %0h, expected no output", result);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                chk("result", result, e.res);
                chk("cout", cout, e.co);
                chk("ovf", ovf, e.ov);
            end
        end
    end

    task automatic send(input vec_t v);
        bit got;
        @(posedge clk); #1;
        op_a = v.a; op_b = v.b; sub = v.sub; cin = v.cin; in_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1");
        end
        exp_q.push_back(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts clock edges from the accept edge until out_valid is seen.
    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (out_valid) break;
        end
    endtask

    vec_t tbl[$];
    vec_t v1, v2, vab;
    int   n;
    bit   seen;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        op_a = 16'h1234; op_b = 16'h0FCD; sub = 1'b0; cin = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_result", result, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);

        tbl.push_back(mk(16'h1234, 16'h0FCD, 0, 0, 16'h2201, 0, 0));
        tbl.push_back(mk(16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0));
        tbl.push_back(mk(16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1));
        tbl.push_back(mk(16'h0005, 16'h0007, 1, 0, 16'hFFFE, 0, 0));
        tbl.push_back(mk(16'h8000, 16'h0001, 1, 0, 16'h7FFF, 1, 1));
        tbl.push_back(mk(16'h0005, 16'h0003, 1, 1, 16'h0001, 1, 0));
        tbl.push_back(mk(16'h00FF, 16'h0001, 0, 1, 16'h0101, 0, 0));
        for (int i = 0; i < 6; i++) begin
            tbl.push_back(model(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom)));
        end

        foreach (tbl[i]) begin
            send(tbl[i]);
            wait_done(n);
            chk("latency", n, 4);
            @(posedge clk); #1;
        end

        // Backpressure: result held while a new operand set is offered.
        v1 = mk(16'h4321, 16'h1111, 1, 0, 16'h3210, 1, 0);
        v2 = model(16'hA5A5, 16'h5A5A, 0, 1);
        out_ready = 1'b0;
        send(v1);
        wait_done(n);
        chk("bp_latency", n, 4);
        @(posedge clk); #1;
        op_a = v2.a; op_b = v2.b; sub = v2.sub; cin = v2.cin; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_result", result, v1.res);
            chk("bp_cout", cout, v1.co);
            chk("bp_ovf", ovf, v1.ov);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1);
        exp_q.push_back(v2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done(n);
        chk("bp_new_latency", n, 4);
        @(posedge clk); #1;

        // Abort during pass k=2 with a carry-heavy operation in flight.
        vab = model(16'hFFFF, 16'hFFFF, 0, 1);
        send(vab);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("abort_no_valid", seen, 0);
        send(mk(16'h0001, 16'h0001, 0, 0, 16'h0002, 0, 0));
        wait_done(n);
        chk("post_abort_latency", n, 4);
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        chk("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
